// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite-style single-ported word RAM slave. One transaction at a time:
// AW->W->B or AR->R, with a programmable wait before each response.
module axi_lite_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] AWdata,
    input  logic [2:0]  awprot,
    input  logic        Wvalid,
    output logic        Wready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  arprot,
    output logic        Rvalid,
    input  logic        RReady,
    output logic [31:0] Rdata
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [2:0] {
        IDLE, AR_ACK, R_WAIT, R_RESP, AW_ACK, W_ACK, B_WAIT, B_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_we;

    logic [31:0] mem [DEPTH];

    // Protection bits and the sub-word / above-depth address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, ARdata[31:ADDR_W+2], ARdata[1:0],
                         AWdata[31:ADDR_W+2], AWdata[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ARvalid) begin
                    state_d   = AR_ACK;
                    arready_d = 1'b1;
                end else if (AWvalid) begin
                    state_d   = AW_ACK;
                    awready_d = 1'b1;
                end
            end
            AR_ACK: begin
                addr_d    = ARdata[ADDR_W+1:2];
                arready_d = 1'b0;
                cnt_d     = LAT;
                state_d   = R_WAIT;
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d  = mem[addr_q];
                    rvalid_d = 1'b1;
                    state_d  = R_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (RReady) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            AW_ACK: begin
                addr_d    = AWdata[ADDR_W+1:2];
                awready_d = 1'b0;
                state_d   = W_ACK;
            end
            W_ACK: begin
                // Wready is raised one cycle after Wvalid is seen; the write lands on the handshake edge.
                if (wready_q) begin
                    if (Wvalid) begin
                        mem_we   = 1'b1;
                        wready_d = 1'b0;
                        cnt_d    = LAT;
                        state_d  = B_WAIT;
                    end
                end else if (Wvalid) begin
                    wready_d = 1'b1;
                end
            end
            B_WAIT: begin
                if (cnt_q == 4'd0) begin
                    bvalid_d = 1'b1;
                    state_d  = B_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            B_RESP: begin
                if (Bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (Wstrb[i]) mem[addr_q][8*i +: 8] <= Wdata[8*i +: 8];
            end
        end
    end

    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign Bvalid  = bvalid_q;
    assign ARready = arready_q;
    assign Rvalid  = rvalid_q;
    assign Rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed + randomized bench for axi_lite_mem_responder with a word-array reference model.
module tb_axi_lite_mem_responder;
    localparam int ADDR_W  = 10;
    localparam int LATENCY = 3;

    logic        clock = 1'b0;
    logic        resetn;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic        ARvalid, ARready, Rvalid, RReady;
    logic [31:0] AWdata, Wdata, ARdata, Rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  Wstrb;

    int          ncmp = 0;
    int          nfail = 0;
    logic        aw_leak;
    logic [31:0] model [1 << ADDR_W];

    axi_lite_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clock(clock), .resetn(resetn),
        .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .awprot(awprot),
        .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid), .Bready(Bready),
        .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .arprot(arprot),
        .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdly);
        int n;
        AWvalid = 1'b1; AWdata = addr; awprot = 3'($urandom);
        n = 0;
        while (!AWready && n < 50) begin tick(); n++; end
        check("aw_ready_seen", 32'(AWready), 32'd1);
        tick(); AWvalid = 1'b0;
        check("aw_ready_pulse", 32'(AWready), 32'd0);
        Wvalid = 1'b1; Wdata = data; Wstrb = strb;
        n = 0;
        while (!Wready && n < 50) begin tick(); n++; end
        check("w_ready_seen", 32'(Wready), 32'd1);
        tick(); Wvalid = 1'b0;
        check("w_ready_pulse", 32'(Wready), 32'd0);
        n = 1;
        while (!Bvalid && n < 50) begin tick(); n++; end
        check("b_latency", 32'(n), 32'(LATENCY + 2));
        for (int k = 0; k < bdly; k++) begin
            tick();
            check("b_hold", 32'(Bvalid), 32'd1);
        end
        Bready = 1'b1; tick(); Bready = 1'b0;
        check("b_pulse", 32'(Bvalid), 32'd0);
        for (int i = 0; i < 4; i++)
            if (strb[i]) model[addr[ADDR_W+1:2]][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdly, input logic [31:0] exp);
        int n;
        ARvalid = 1'b1; ARdata = addr; arprot = 3'($urandom);
        n = 0;
        while (!ARready && n < 50) begin aw_leak |= AWready; tick(); n++; end
        check("ar_ready_seen", 32'(ARready), 32'd1);
        tick(); ARvalid = 1'b0;
        check("ar_ready_pulse", 32'(ARready), 32'd0);
        n = 1;
        while (!Rvalid && n < 50) begin aw_leak |= AWready; tick(); n++; end
        check("r_latency", 32'(n), 32'(LATENCY + 2));
        check("rdata", Rdata, exp);
        for (int k = 0; k < rdly; k++) begin
            tick();
            aw_leak |= AWready;
            check("r_hold_valid", 32'(Rvalid), 32'd1);
            check("r_hold_data", Rdata, exp);
        end
        RReady = 1'b1; tick(); RReady = 1'b0;
        check("r_pulse", 32'(Rvalid), 32'd0);
        check("rdata_held", Rdata, exp);
    endtask

    initial begin
        int n;
        int pool [8];
        logic [31:0] a;
        logic [3:0]  s;
        resetn = 1'b0;
        AWvalid = 0; Wvalid = 0; Bready = 0; ARvalid = 0; RReady = 0;
        AWdata = 0; Wdata = 0; ARdata = 0; Wstrb = 0; awprot = 0; arprot = 0;
        aw_leak = 1'b0;
        repeat (3) tick();
        check("rst_rdata", Rdata, 32'd0);
        check("rst_valids", {28'd0, Rvalid, Bvalid, ARready, AWready}, 32'd0);
        check("rst_wready", 32'(Wready), 32'd0);
        resetn = 1'b1;
        tick();

        // Word write/read, byte strobe, backpressure with latency
        axi_write(32'h0000_0010, 32'hDEADBEEF, 4'b1111, 0);
        axi_read(32'h0000_0010, 0, 32'hDEADBEEF);
        axi_write(32'h0000_0012, 32'hA5A5A5A5, 4'b0100, 0);
        axi_read(32'h0000_0010, 0, 32'hDEA5BEEF);
        axi_read(32'h0000_0013, 0, 32'hDEA5BEEF);
        axi_read(32'h0000_0010, 5, 32'hDEA5BEEF);
        axi_write(32'h0000_0010, 32'h01234567, 4'b0000, 2);
        axi_read(32'h0000_0011, 1, 32'hDEA5BEEF);

        // Read wins over a simultaneous write; AW must wait for the read to finish
        aw_leak = 1'b0;
        AWvalid = 1'b1; AWdata = 32'h0000_0020;
        axi_read(32'h0000_0010, 0, 32'hDEA5BEEF);
        check("prio_no_aw_during_read", 32'(aw_leak), 32'd0);
        axi_write(32'h0000_0020, 32'h55AA55AA, 4'b1111, 0);
        axi_read(32'h0000_0020, 0, 32'h55AA55AA);

        // Aliasing above depth
        axi_write(32'h0000_1004, 32'h11223344, 4'b1111, 0);
        axi_read(32'h0000_0004, 0, 32'h11223344);

        // Reset while holding a read response
        axi_write(32'h0000_0040, 32'hCAFEF00D, 4'b1111, 0);
        ARvalid = 1'b1; ARdata = 32'h0000_0040;
        n = 0;
        while (!ARready && n < 50) begin tick(); n++; end
        tick(); ARvalid = 1'b0;
        n = 0;
        while (!Rvalid && n < 50) begin tick(); n++; end
        check("pre_rst_rdata", Rdata, 32'hCAFEF00D);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valids", {28'd0, Rvalid, Bvalid, ARready, AWready}, 32'd0);
        check("mid_rst_rdata", Rdata, 32'd0);
        tick(); resetn = 1'b1;
        tick();
        check("post_rst_arready", 32'(ARready), 32'd0);
        check("post_rst_rvalid", 32'(Rvalid), 32'd0);
        axi_read(32'h0000_0040, 0, 32'hCAFEF00D);

        // Randomized traffic over a pool of words with aliased / misaligned addresses
        for (int i = 0; i < 8; i++) begin
            pool[i] = 100 + 37 * i;
            a = $urandom; a[ADDR_W+1:2] = 10'(pool[i]);
            axi_write(a, $urandom, 4'b1111, int'($urandom_range(2)));
        end
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(7));
            a = $urandom; a[ADDR_W+1:2] = 10'(pool[n]);
            if ($urandom_range(1) == 0) begin
                s = 4'($urandom);
                axi_write(a, $urandom, s, int'($urandom_range(3)));
            end else begin
                axi_read(a, int'($urandom_range(3)), model[a[ADDR_W+1:2]]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
